// File: rtl/fifo_readout.sv
// fifo_readout: pops words from a FIFO and streams them to a byte transmitter,
// least-significant byte first, with an optional trailing XOR checksum byte.
// Optional feature macro: READOUT_CHECKSUM_EN (adds the TRAIL state and the
// checksum register; when undefined the burst ends straight after the data).
module fifo_readout #(
  parameter int WIDTH     = 5,
  parameter int WIDTH_cnt = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [15:0]                  sample_cnt_i,
  input  logic                         EMPTY_i,
  output logic                         POP_o,
  input  logic [WIDTH*WIDTH_cnt-1:0]   DO_i,
  output logic [7:0]                   tx_data_o,
  output logic                         tx_valid_o,
  input  logic                         tx_ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [15:0]                  words_read_o
);

  localparam int DATA_W  = WIDTH * WIDTH_cnt;
  localparam int NBYTES  = (DATA_W + 7) / 8;
  localparam int SHIFT_W = NBYTES * 8;
  localparam int IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_SEND,
`ifdef READOUT_CHECKSUM_EN
    S_TRAIL,
`endif
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          remaining_q, remaining_d;
  logic                 drain_q, drain_d;     // sample count 0: read until EMPTY_i
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [15:0]          words_q, words_d;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  // State and datapath registers; reset drops any word popped but not yet sent.
  // NOTE: every register here is cleared by the async reset, and sequential
  // state is written with non-blocking assignments only so all flops update
  // together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= 16'h0000;
      drain_q     <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      words_q     <= 16'h0000;
`ifdef READOUT_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      words_q     <= words_d;
`ifdef READOUT_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state and output decode for the readout sequence.
  // NOTE: every signal assigned below gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    words_d     = words_q;
`ifdef READOUT_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    POP_o       = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          remaining_d = sample_cnt_i;
          drain_d     = (sample_cnt_i == 16'h0000);
          words_d     = 16'h0000;
`ifdef READOUT_CHECKSUM_EN
          csum_d      = 8'h00;
`endif
          state_d     = S_CHECK;
        end
      end

      S_CHECK: begin
        // Pop is gated by EMPTY_i here, so it can never fire on an empty FIFO.
        if ((!drain_q && (remaining_q == 16'h0000)) || EMPTY_i) begin
`ifdef READOUT_CHECKSUM_EN
          state_d = S_TRAIL;
`else
          state_d = S_DONE;
`endif
        end else begin
          POP_o   = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // DO_i is valid one cycle after the pop; capture it zero-extended.
        shift_d = SHIFT_W'(DO_i);
        idx_d   = '0;
        state_d = S_SEND;
      end

      S_SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = shift_q[7:0];
        if (tx_ready_i) begin
          shift_d = shift_q >> 8;
          idx_d   = idx_q + IDX_W'(1);
`ifdef READOUT_CHECKSUM_EN
          csum_d  = csum_q ^ shift_q[7:0];
`endif
          if (idx_q == LAST_IDX) begin
            words_d = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;
            if (!drain_q) begin
              remaining_d = remaining_q - 16'd1;
            end
            state_d = S_CHECK;
          end
        end
      end

`ifdef READOUT_CHECKSUM_EN
      S_TRAIL: begin
        tx_valid_o = 1'b1;
        tx_data_o  = csum_q;
        if (tx_ready_i) begin
          state_d = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign words_read_o = words_q;

endmodule

// File: tb/tb_fifo_readout.sv
// tb_fifo_readout: directed and randomized bursts against a queue-level model
// of the readout (words taken from a FIFO array, split into bytes LSB first).
module tb_fifo_readout;

  localparam int WIDTH     = 5;
  localparam int WIDTH_CNT = 3;
  localparam int DATA_W    = WIDTH * WIDTH_CNT;
  localparam int NBYTES    = (DATA_W + 7) / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_i = 1'b0;
  logic [15:0]       sample_cnt_i = 16'h0000;
  logic              EMPTY_i;
  logic              POP_o;
  logic [DATA_W-1:0] DO_i;
  logic [7:0]        tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i = 1'b1;
  logic              busy_o;
  logic              done_o;
  logic [15:0]       words_read_o;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_readout #(.WIDTH(WIDTH), .WIDTH_cnt(WIDTH_CNT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .sample_cnt_i (sample_cnt_i),
    .EMPTY_i      (EMPTY_i),
    .POP_o        (POP_o),
    .DO_i         (DO_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .words_read_o (words_read_o)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read, data appears the cycle after the pop.
  logic [DATA_W-1:0] mem [0:1023];
  int                wr_ptr = 0;
  int                rd_ptr = 0;
  logic [DATA_W-1:0] do_q = '0;

  assign EMPTY_i = (rd_ptr == wr_ptr);
  assign DO_i    = do_q;

  always @(posedge clk) begin
    if (POP_o && (rd_ptr != wr_ptr)) begin
      do_q   <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor sampled on the falling edge, away from the active edge.
  logic [7:0] got[$];
  int   pop_cnt = 0;
  int   done_cnt = 0;
  int   pop_empty_err = 0;
  int   hold_err = 0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && !(tx_valid_o && (tx_data_o == prev_data))) hold_err++;
      if (tx_valid_o && tx_ready_i) got.push_back(tx_data_o);
      if (POP_o) pop_cnt++;
      if (POP_o && EMPTY_i) pop_empty_err++;
      if (done_o) done_cnt++;
      prev_hold = tx_valid_o && !tx_ready_i;
      prev_data = tx_data_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // mode 0: always ready; 1: random ready; 2: ready low cycles 3..6;
  // 3: always ready with a stray start pulse while busy.
  task automatic run_burst(input logic [15:0] cnt, input int mode);
    int avail, n, got_base, pop_base, done_base;
    logic [7:0] exp_q[$];
    logic [7:0] x;
    logic [15:0] w;
    bit seen;
    avail = wr_ptr - rd_ptr;
    if (cnt == 16'h0000) n = avail;
    else n = (int'(cnt) < avail) ? int'(cnt) : avail;
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = 16'(mem[rd_ptr + k]);
      for (int b = 0; b < NBYTES; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
`ifdef READOUT_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    got_base  = got.size();
    pop_base  = pop_cnt;
    done_base = done_cnt;

    @(posedge clk); #1;
    start_i      = 1'b1;
    sample_cnt_i = cnt;
    tx_ready_i   = 1'b1;
    @(posedge clk); #1;            // edge 0: start sampled
    start_i      = 1'b0;
    sample_cnt_i = 16'($urandom);
    seen = 1'b0;
    for (int cyc = 1; cyc <= 300 && !seen; cyc++) begin
      start_i = 1'b0;
      case (mode)
        1: tx_ready_i = 1'($urandom_range(0, 1));
        2: tx_ready_i = !(cyc >= 3 && cyc <= 6);
        3: begin
          tx_ready_i = 1'b1;
          if (cyc == 4) begin
            start_i      = 1'b1;
            sample_cnt_i = 16'h0007;
          end
        end
        default: tx_ready_i = 1'b1;
      endcase
      @(negedge clk);
      if (cyc == 1) check("pop_latency", 32'(POP_o), 32'(n > 0));
      if (cyc == 3 && n > 0) check("valid_latency", 32'(tx_valid_o), 32'd1);
      if (mode == 2 && cyc == 6 && n > 0) begin
        check("hold_valid", 32'(tx_valid_o), 32'd1);
        check("hold_data", 32'(tx_data_o), 32'(exp_q[0]));
      end
      if (done_cnt != done_base) seen = 1'b1;
      @(posedge clk); #1;
    end
    start_i    = 1'b0;
    tx_ready_i = 1'b1;
    check("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("busy_idle", 32'(busy_o), 32'd0);
    check("words_read", 32'(words_read_o), 32'(n));
    check("pop_count", 32'(pop_cnt - pop_base), 32'(n));
    check("done_count", 32'(done_cnt - done_base), 32'd1);
    check("byte_count", 32'(got.size() - got_base), 32'(exp_q.size()));
    if (got.size() - got_base == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        check($sformatf("byte%0d", i), 32'(got[got_base + i]), 32'(exp_q[i]));
      end
    end
    check("pop_while_empty", 32'(pop_empty_err), 32'd0);
    check("data_hold", 32'(hold_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop_snap, got_snap, nw;
    // Reset state.
    #12;
    check("rst_pop", 32'(POP_o), 32'd0);
    check("rst_valid", 32'(tx_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_data", 32'(tx_data_o), 32'd0);
    check("rst_words", 32'(words_read_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Count 2, always ready.
    push(15'h1234); push(15'h0ABC);
    run_burst(16'd2, 0);
    // Drain mode.
    push(15'h1234); push(15'h0ABC);
    run_burst(16'd0, 0);
    // Count larger than contents: early end.
    push(15'h1234); push(15'h0ABC);
    run_burst(16'd5, 1);
    // Backpressure during byte 0.
    push(15'h1234); push(15'h0ABC);
    run_burst(16'd2, 2);
    // Start pulse while busy is ignored.
    push(15'h1234); push(15'h0ABC);
    run_burst(16'd2, 3);
    // Zero-word burst on an empty FIFO.
    run_burst(16'd0, 0);

    // Reset during SEND of the second word.
    push(15'h1234); push(15'h0ABC); push(15'h7E55);
    @(posedge clk); #1;
    start_i = 1'b1; sample_cnt_i = 16'd2; tx_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int cyc = 1; cyc < 7; cyc++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("pre_rst_valid", 32'(tx_valid_o), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_pop", 32'(POP_o), 32'd0);
    check("mid_rst_valid", 32'(tx_valid_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    check("mid_rst_data", 32'(tx_data_o), 32'd0);
    check("mid_rst_words", 32'(words_read_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    pop_snap = pop_cnt;
    got_snap = got.size();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    check("post_rst_no_pop", 32'(pop_cnt - pop_snap), 32'd0);
    check("post_rst_no_byte", 32'(got.size() - got_snap), 32'd0);
    check("post_rst_idle", 32'(busy_o), 32'd0);
    run_burst(16'd1, 0);

    // Randomized bursts.
    for (int t = 0; t < 12; t++) begin
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) push(DATA_W'($urandom));
      run_burst(16'($urandom_range(0, 4)), $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
